// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM slice.
// State encoding, read-mode selectors and a depth helper.
package ram_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Bare simple dual-port array: one write port, one registered read port.
// Ports: clk/rst_n, we/waddr/wdata write, re/raddr read, rdata registered out.
module ram_dp_core
  import ram_pkg::*;
#(
  parameter int p_data_width    = 8,
  parameter int p_address_width = 10,
  parameter int p_read_mode     = READ_FIRST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [p_address_width-1:0] waddr,
  input  logic [p_data_width-1:0]    wdata,
  input  logic                       re,
  input  logic [p_address_width-1:0] raddr,
  output logic [p_data_width-1:0]    rdata
);

  localparam int unsigned DEPTH = depth_of(p_address_width);

  logic [p_data_width-1:0] mem [DEPTH];
  logic                    hit;

  // Same-address collision forwards the incoming word in write-first mode.
  assign hit = (p_read_mode == WRITE_FIRST) && we && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= hit ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ram_dp_sweep.sv
// Dual-port RAM with collision mode and a clear engine sweeping all words.
// Ports: clk/rst_n, clear/busy, we/wr_address/in, oe/rd_address, out/valid.
module ram_dp_sweep
  import ram_pkg::*;
#(
  parameter int                    p_data_width    = 8,
  parameter int                    p_address_width = 10,
  parameter int                    p_read_mode     = READ_FIRST,
  parameter logic [p_data_width-1:0] p_clear_value = '0
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_clear,
  output logic                       o_w_busy,
  input  logic                       i_w_we,
  input  logic [p_address_width-1:0] i_w_wr_address,
  input  logic [p_data_width-1:0]    i_w_in,
  input  logic                       i_w_oe,
  input  logic [p_address_width-1:0] i_w_rd_address,
  output logic [p_data_width-1:0]    o_w_out,
  output logic                       o_w_valid
);

  state_t                     state, state_d;
  logic [p_address_width-1:0] cnt, cnt_d;
  logic                       we;
  logic [p_address_width-1:0] waddr;
  logic [p_data_width-1:0]    wdata;
  logic                       re;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state     <= SWEEP;
      cnt       <= '0;
      o_w_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      o_w_valid <= re;
    end
  end

  // The sweep owns the write port; a clear request drops that cycle's access.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we      = 1'b0;
    waddr   = i_w_wr_address;
    wdata   = i_w_in;
    re      = 1'b0;
    unique case (state)
      SWEEP: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = p_clear_value;
        cnt_d = cnt + 1'b1;
        if (&cnt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (i_w_clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          we = i_w_we;
          re = i_w_oe;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  assign o_w_busy = (state == SWEEP);

  ram_dp_core #(
    .p_data_width   (p_data_width),
    .p_address_width(p_address_width),
    .p_read_mode    (p_read_mode)
  ) u_core (
    .clk  (i_w_clk),
    .rst_n(i_w_rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(i_w_rd_address),
    .rdata(o_w_out)
  );

endmodule

// File: tb/tb_ram_dp_sweep.sv
// Scoreboard bench for ram_dp_sweep: two instances (read-first/clear 0,
// write-first/clear A5 with 16 words) driven by the same stimulus.
module tb_ram_dp_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic       oe = 1'b0;
  logic [9:0] wa = '0;
  logic [9:0] ra = '0;
  logic [7:0] wd = '0;

  logic       busy0, busy1, valid0, valid1;
  logic [7:0] out0, out1;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem [2][1024];
  int         bl [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int         amask [2] = '{1023, 15};
  int         dep   [2] = '{1024, 16};
  bit         wfirst[2] = '{1'b0, 1'b1};
  logic [7:0] cval  [2] = '{8'h00, 8'hA5};

  always #5 clk = ~clk;

  ram_dp_sweep #(
    .p_data_width(8), .p_address_width(10),
    .p_read_mode(0), .p_clear_value(8'h00)
  ) dut0 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_clear(clr),
    .o_w_busy(busy0), .i_w_we(we), .i_w_wr_address(wa),
    .i_w_in(wd), .i_w_oe(oe), .i_w_rd_address(ra),
    .o_w_out(out0), .o_w_valid(valid0)
  );

  ram_dp_sweep #(
    .p_data_width(8), .p_address_width(4),
    .p_read_mode(1), .p_clear_value(8'hA5)
  ) dut1 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_clear(clr),
    .o_w_busy(busy1), .i_w_we(we), .i_w_wr_address(wa[3:0]),
    .i_w_in(wd), .i_w_oe(oe), .i_w_rd_address(ra[3:0]),
    .o_w_out(out1), .o_w_valid(valid1)
  );

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected word whenever a DUT presents valid data.
  always @(negedge clk) begin
    if (valid0) begin
      if (q0.size() == 0) chk("dut0 unexpected valid", 1, 0);
      else chk("dut0 read", int'(out0), int'(q0.pop_front()));
    end
    if (valid1) begin
      if (q1.size() == 0) chk("dut1 unexpected valid", 1, 0);
      else chk("dut1 read", int'(out1), int'(q1.pop_front()));
    end
  end

  function automatic void fill(input int d);
    for (int i = 0; i < 1024; i++) mem[d][i] = cval[d];
  endfunction

  // Reference: a clear or reset fills the array and blocks access for
  // exactly depth cycles; otherwise reads/writes act on plain arrays.
  task automatic step(input bit w, input int wadr, input int wdat,
                      input bit o, input int radr, input bit c);
    we = w; wa = 10'(wadr); wd = 8'(wdat);
    oe = o; ra = 10'(radr); clr = c;
    for (int d = 0; d < 2; d++) begin
      int aw, ar;
      logic [7:0] e;
      aw = wadr & amask[d];
      ar = radr & amask[d];
      if (bl[d] > 0) begin
        bl[d]--;
      end else if (c) begin
        bl[d] = dep[d];
        fill(d);
      end else begin
        if (o) begin
          e = (w && aw == ar && wfirst[d]) ? 8'(wdat) : mem[d][ar];
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        if (w) mem[d][aw] = 8'(wdat);
      end
    end
    @(posedge clk);
    #1;
    chk("dut0 busy", int'(busy0), int'(bl[0] > 0));
    chk("dut1 busy", int'(busy1), int'(bl[1] > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 0, 1, a, 0);
  endtask

  task automatic wr(input int a, input int v);
    step(1, a, v, 0, 0, 0);
  endtask

  initial begin
    bl[0] = 1024;
    bl[1] = 16;
    fill(0);
    fill(1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy0", int'(busy0), 1);
    chk("reset out0", int'(out0), 0);
    chk("reset valid0", int'(valid0), 0);
    chk("reset out1", int'(out1), 0);
    rst_n = 1'b1;

    // Accesses during the sweep must be dropped.
    for (int i = 0; i < 10; i++) step(1, 5, 8'h33, 1, 5, 0);
    idle(10);
    rd(5);
    idle(1024 - 21);
    chk("busy fell after 1024", int'(busy0), 0);

    rd(0); rd(511); rd(1023); rd(5);
    wr(2, 3); rd(2);
    wr(3, 3); rd(3);

    // Collision: old word 7, new word 9.
    wr(5, 7);
    step(1, 5, 9, 1, 5, 0);
    rd(5);

    for (int i = 0; i < 300; i++) begin
      int a;
      a = int'($urandom_range(0, 15));
      step(bit'($urandom % 2), a, int'($urandom % 256), bit'($urandom % 2),
           ($urandom % 3 == 0) ? a : int'($urandom_range(0, 15)), 0);
    end

    // Clear sweep with a request-cycle access that must be dropped.
    wr(2, 2); wr(3, 3); rd(3);
    step(1, 2, 8'h77, 1, 2, 1);
    chk("busy rose on clear", int'(busy0), 1);
    idle(1023);
    chk("busy still high", int'(busy0), 1);
    idle(1);
    rd(2); rd(3);

    // Reset in the middle of a sweep.
    wr(3, 8'h5C); rd(3);
    step(0, 0, 0, 0, 0, 1);
    idle(299);
    rst_n = 1'b0;
    #1;
    chk("midreset busy0", int'(busy0), 1);
    chk("midreset out0", int'(out0), 0);
    chk("midreset out1", int'(out1), 0);
    bl[0] = 1024;
    bl[1] = 16;
    fill(0);
    fill(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1023);
    chk("post-reset busy", int'(busy0), 1);
    idle(1);
    rd(3); rd(1000); rd(0);
    idle(3);
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_dp_sweep.md
# ram_dp_sweep

Parametrised simple dual-port synchronous RAM: one write port, one registered read port, a selectable read-during-write collision mode, and a hardware clear engine. The clear engine sweeps every word to a constant after reset or on request. The block is the general memory primitive for the memory chapter designs. It supersedes the single-port oe/we RAM: reads and writes can now use different addresses in the same cycle, and a known post-reset memory state is guaranteed.

## Interface
- p_data_width, 8, word width in bits
- p_address_width, 10, address width; depth = 2^p_address_width words
- p_read_mode, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new data)
- p_clear_value, 0, word written to every location during a sweep (p_data_width bits)

Ports:
- i_w_clk  input  1  clock; all state updates on the rising edge
- i_w_rst_n  input  1  reset, asynchronous, active-low
- i_w_clear  input  1  one-cycle request to start a clear sweep
- o_w_busy  output  1  high while a sweep is in progress
- i_w_we  input  1  write enable
- i_w_wr_address  input  p_address_width  write address
- i_w_in  input  p_data_width  write data
- i_w_oe  input  1  read enable
- i_w_rd_address  input  p_address_width  read address
- o_w_out  output  p_data_width  registered read data
- o_w_valid  output  1  high for one cycle when o_w_out carries a freshly read word

## Operation
- FSM states: SWEEP, IDLE.
- Asynchronous reset (i_w_rst_n = 0):
  - state = SWEEP, sweep counter = 0.
  - Reset values: o_w_busy = 1, o_w_out = 0, o_w_valid = 0.
  - The array contents are not reset directly; the sweep initialises them.
- SWEEP:
  - Each cycle, write p_clear_value to mem[counter], then counter += 1.
  - When counter = depth-1 has been written, go to IDLE and clear the counter. The counter never wraps past depth-1.
  - i_w_we, i_w_oe and i_w_clear are ignored. o_w_valid = 0. o_w_out holds its value.
- IDLE:
  - i_w_we = 1 writes i_w_in to mem[i_w_wr_address].
  - i_w_oe = 1 loads o_w_out with mem[i_w_rd_address]; o_w_valid = 1 on the following cycle.
  - i_w_oe = 0: o_w_out holds its last value; o_w_valid = 0.
  - i_w_clear = 1 moves to SWEEP with counter = 0. Any write or read presented in that same cycle is dropped.
- Collision (i_w_we and i_w_oe both high, same address, IDLE): p_read_mode selects old or new data on o_w_out. Different addresses never interact.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release. Partially swept contents are overwritten.
- Addresses are full-range; no out-of-range case exists.

## Timing
- Read latency is 1 cycle: request sampled at edge N, data and o_w_valid visible after edge N, held until edge N+1.
- Write takes effect at the sampling edge. A read of that address at edge N+1 or later returns the new data.
- A sweep lasts exactly 2^p_address_width cycles.
  - o_w_busy falls after the edge that writes the last word. The first accepted access is at the next edge.
  - With the defaults, busy lasts 1024 cycles after reset release.
- o_w_busy is registered; it is never combinational from i_w_clear. It rises at the edge that samples i_w_clear = 1.

## Structure
- Shared package ram_pkg holds:
  - the state encoding (SWEEP, IDLE),
  - the read-mode constants (READ_FIRST = 0, WRITE_FIRST = 1),
  - a depth helper constant derived from address width.
- Sub-module ram_dp_core: bare array with one write port and one registered read port, plus the collision mux.
- Top level holds the sweep FSM and counter, and muxes the write port between the sweep engine and the user port.

## Test plan
- Reset release with defaults:
  - busy = 1 for 1024 cycles, then 0.
  - Read of addresses 0, 511 and 1023 -> o_w_out = 0, o_w_valid pulses 1 cycle after each oe.
- Write 3 to address 2, then on the next cycle oe at address 2 -> o_w_out = 3 one cycle later. Repeat for address 3 with value 3.
- Same-cycle we/oe at address 5, old word 7, new word 9:
  - p_read_mode = 0 -> o_w_out = 7.
  - p_read_mode = 1 -> o_w_out = 9.
  - Read again next cycle -> 9.
- we and oe asserted during a sweep -> no write occurs, o_w_valid stays 0. After the sweep, the targeted address reads p_clear_value (use 8'hA5).
- Fill addresses 2 and 3 with 2 and 3, then pulse i_w_clear:
  - busy rises at that edge and lasts 1024 cycles.
  - Both addresses then read 0.
- Assert i_w_rst_n = 0 at sweep cycle 300 -> busy stays 1, o_w_out = 0 immediately. After release, the sweep runs a full 1024 cycles.
